// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry {result, flag} FIFO plus the architectural flag register (flag_q).
// Latency 1 cycle; in_ready = not full; optional out_zero head-zero detect under ALU_WB_ZERO_FLAG_EN.
module alu_wb_stage #(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [ANCHO-1:0] alu_result,
  input  logic             alu_flags,
  output logic             flag_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ANCHO-1:0] out_result,
  output logic             out_flag,
  output logic [1:0]       count
`ifdef ALU_WB_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  logic [ANCHO-1:0] r_mem_res [2];
  logic [1:0]       r_mem_flag;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_flag_q;

  logic             w_push;
  logic             w_pop;
  logic             w_flag_op;
  logic             w_legal;
  logic [ANCHO-1:0] w_push_res;
  logic             w_push_flag;

  always_comb begin
    w_flag_op = 1'b0;
    w_legal   = 1'b0;
    case (alu_control)
      4'h2, 4'h6, 4'h8, 4'h9: begin
        w_flag_op = 1'b1;
        w_legal   = 1'b1;
      end
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h7: w_legal = 1'b1;
      default: ;
    endcase
  end

  // Illegal ops store a clean zero entry so an undefined result word never reaches the outputs.
  assign w_push_res  = w_legal ? alu_result : '0;
  assign w_push_flag = w_flag_op ? alu_flags : (w_legal ? r_flag_q : 1'b0);

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_res[0] <= '0;
      r_mem_res[1] <= '0;
      r_mem_flag   <= '0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_count      <= 2'd0;
      r_flag_q     <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_res[r_wr_ptr]  <= w_push_res;
        r_mem_flag[r_wr_ptr] <= w_push_flag;
        r_wr_ptr             <= ~r_wr_ptr;
        if (w_flag_op) r_flag_q <= alu_flags;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: ;
      endcase
    end
  end

  assign out_result = r_mem_res[r_rd_ptr];
  assign out_flag   = r_mem_flag[r_rd_ptr];
  assign flag_q     = r_flag_q;
  assign count      = r_count;

`ifdef ALU_WB_ZERO_FLAG_EN
  assign out_zero = out_valid & (out_result == '0);
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: directed pushes enqueue hand-computed entries, a monitor checks pops.
module tb_alu_wb_stage;
  localparam int ANCHO = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [3:0]       alu_control = '0;
  logic [ANCHO-1:0] alu_result = '0;
  logic             alu_flags = 1'b0;
  logic             in_ready;
  logic             flag_q;
  logic             out_valid;
  logic [ANCHO-1:0] out_result;
  logic             out_flag;
  logic [1:0]       count;
`ifdef ALU_WB_ZERO_FLAG_EN
  logic             out_zero;
`endif

  typedef struct packed {
    logic [ANCHO-1:0] res;
    logic             flg;
  } ent_t;

  ent_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  alu_wb_stage #(.ANCHO(ANCHO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .flag_q     (flag_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flag   (out_flag),
    .count      (count)
`ifdef ALU_WB_ZERO_FLAG_EN
    ,
    .out_zero   (out_zero)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic do_push(input logic [3:0] op, input logic [ANCHO-1:0] res, input logic flg,
                         input logic [ANCHO-1:0] e_res, input logic e_flg);
    int   waited;
    ent_t e;
    alu_control = op;
    alu_result  = res;
    alu_flags   = flg;
    in_valid    = 1'b1;
    waited      = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL push_timeout: in_ready=%0b, required 1", in_ready);
    end else begin
      e.res = e_res;
      e.flg = e_flg;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int waited = 0;
    @(negedge clk);
    while ((count != 2'd0 || sb.size() != 0) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid & ready hold at the falling edge.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL pop_unexpected: out_result=%0h, no entry expected", out_result);
        end else begin
          e = sb.pop_front();
          chk("pop_result", 32'(out_result), 32'(e.res));
          chk("pop_flag", 32'(out_flag), 32'(e.flg));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_flag_q", 32'(flag_q), 32'd0);
    rst_n = 1'b1;

    // Flag op loads flag_q; result visible one cycle later.
    out_ready = 1'b0;
    do_push(4'h2, 4'hF, 1'b1, 4'hF, 1'b1);
    chk("p1_out_valid", 32'(out_valid), 32'd1);
    chk("p1_out_result", 32'(out_result), 32'hF);
    chk("p1_out_flag", 32'(out_flag), 32'd1);
    chk("p1_flag_q", 32'(flag_q), 32'd1);
    chk("p1_count", 32'(count), 32'd1);

    // Non-flag op stores the current flag_q.
    do_push(4'h0, 4'h3, 1'b0, 4'h3, 1'b1);
    chk("p2_count", 32'(count), 32'd2);
    chk("p2_in_ready", 32'(in_ready), 32'd0);
    chk("p2_flag_q", 32'(flag_q), 32'd1);
    chk("p2_head_result", 32'(out_result), 32'hF);

    // Full: third push is held while out_ready is low.
    alu_control = 4'h8;
    alu_result  = 4'h5;
    alu_flags   = 1'b0;
    in_valid    = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_count", 32'(count), 32'd2);
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    chk("hold_head_result", 32'(out_result), 32'hF);
    chk("hold_head_flag", 32'(out_flag), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    do_push(4'h8, 4'h5, 1'b0, 4'h5, 1'b0);
    chk("p3_count", 32'(count), 32'd1);
    chk("p3_out_result", 32'(out_result), 32'h5);
    chk("p3_flag_q", 32'(flag_q), 32'd0);

    // Illegal op with undefined result.
    do_push(4'h9, 4'h1, 1'b1, 4'h1, 1'b1);
    chk("op9_flag_q", 32'(flag_q), 32'd1);
    do_push(4'hB, 4'bxxxx, 1'b1, 4'h0, 1'b0);
    chk("illegal_out_result", 32'(out_result), 32'h0);
    chk("illegal_out_flag", 32'(out_flag), 32'd0);
    chk("illegal_flag_q", 32'(flag_q), 32'd1);
`ifdef ALU_WB_ZERO_FLAG_EN
    chk("illegal_out_zero", 32'(out_zero), 32'd1);
`endif
    do_push(4'h3, 4'h7, 1'b0, 4'h7, 1'b1);
    chk("op3_out_flag", 32'(out_flag), 32'd1);
    chk("op3_flag_q", 32'(flag_q), 32'd1);
    wait_empty();

    // Streaming push+pop: occupancy stays at one, head tracks the last push.
    for (int i = 0; i < 9; i++) begin
      do_push(4'h1, 4'(i + 4), 1'b0, 4'(i + 4), 1'b1);
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_out_result", 32'(out_result), 32'(i + 4));
    end
    wait_empty();

    // Reset between edges with a full FIFO.
    out_ready = 1'b0;
    do_push(4'h2, 4'h1, 1'b1, 4'h1, 1'b1);
    do_push(4'h0, 4'h2, 1'b0, 4'h2, 1'b1);
    chk("prerst_count", 32'(count), 32'd2);
    chk("prerst_flag_q", 32'(flag_q), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_flag_q", 32'(flag_q), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("postrst_out_valid", 32'(out_valid), 32'd0);
    end

    // Push accepted on the first edge after release.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    do_push(4'h6, 4'hA, 1'b1, 4'hA, 1'b1);
    chk("first_edge_count", 32'(count), 32'd1);
    chk("first_edge_result", 32'(out_result), 32'hA);
    chk("first_edge_flag_q", 32'(flag_q), 32'd1);
    wait_empty();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 SHALL have parameter ANCHO, default 4, datapath width matching the upstream ALU result width.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream ALU result presented this cycle.
REQ-005 SHALL have port in_ready  output  1  stage can accept a result this cycle.
REQ-006 SHALL have port alu_control  input  4  opcode that produced alu_result.
REQ-007 SHALL have port alu_result  input  ANCHO  ALU result word.
REQ-008 SHALL have port alu_flags  input  1  ALU carry/shift-out flag.
REQ-009 SHALL have port flag_q  output  1  architectural flag register, wired to the ALU ALUFlagIN input.
REQ-010 SHALL have port out_valid  output  1  head entry available downstream.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the head entry.
REQ-012 SHALL have port out_result  output  ANCHO  head entry result.
REQ-013 SHALL have port out_flag  output  1  head entry flag.
REQ-014 SHALL have port count  output  2  occupancy, 0..2.

Function
REQ-015 SHALL implement a 2-entry FIFO of {result, flag}, with push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-016 SHALL drive in_ready = (count != 2), combinationally from registered state only, with no dependence on out_ready.
REQ-017 SHALL drive out_valid = (count != 0), with out_result and out_flag always showing the oldest entry.
REQ-018 SHALL give a latency of exactly 1 cycle: a result pushed at edge N is visible at the outputs after edge N, never combinationally in the push cycle.
REQ-019 SHALL classify alu_control 4'h2, 4'h6, 4'h8 and 4'h9 as flag ops, 4'h0-4'h9 as legal, and 4'hA-4'hF as illegal.
REQ-020 SHALL, on a push of a flag op, store alu_flags with the entry and load flag_q <= alu_flags.
REQ-021 SHALL, on a push of a non-flag legal op, store the current flag_q with the entry and leave flag_q unchanged.
REQ-022 SHALL, on a push of an illegal op, store result all-zeros and flag 0, leave flag_q unchanged, and never propagate X.
REQ-023 SHALL, on simultaneous push and pop with count 1, keep count at 1, make the new entry the head, and update flag_q per REQ-020/021.
REQ-024 SHALL, on simultaneous push and pop with count 0, ignore the pop (out_valid is 0) and set count to 1.
REQ-025 SHALL wrap the read and write pointers modulo 2, and count SHALL never exceed 2 or underflow below 0.
REQ-026 SHALL, when count is 2, not push even if in_valid is high, and the upstream SHALL hold its data until in_ready is high.
REQ-027 SHALL keep out_result and out_flag stable while out_valid is high and out_ready is low.

Reset
REQ-028 SHALL, while rst_n is low, immediately force count=0, pointers=0, flag_q=0, out_valid=0 and in_ready=1, regardless of clk.
REQ-029 SHALL, on assertion of rst_n mid-operation, discard all stored entries, which SHALL NOT reappear after rst_n is released.
REQ-030 SHALL accept a push on the first rising clk edge after rst_n is released.

Configuration
REQ-031 SHALL, with macro ALU_WB_ZERO_FLAG_EN defined, add port out_zero  output  1, equal to 1 when the head entry result is all zeros and out_valid is high, and 0 otherwise (0 in reset).
REQ-032 SHALL, with ALU_WB_ZERO_FLAG_EN undefined, have no out_zero port and no zero-detect logic, with all other behaviour identical.

Verification
REQ-033 SHALL cover: reset, then push op 4'h2 result 4'hF flag 1 -> next cycle out_valid=1, out_result=4'hF, out_flag=1, flag_q=1, count=1.
REQ-034 SHALL cover: flag_q=1, push op 4'h0 result 4'h3 flag 0 -> entry flag=1, flag_q stays 1.
REQ-035 SHALL cover: out_ready=0, push 3 results back-to-back -> count=2, in_ready=0 after 2nd push, 3rd held; out_ready=1 -> pops in order, 3rd accepted afterward.
REQ-036 SHALL cover: count=1 with simultaneous push/pop every cycle for 8 cycles -> count stays 1, outputs follow inputs with 1-cycle delay.
REQ-037 SHALL cover: push op 4'hB with alu_result=X -> out_result=4'h0, out_flag=0, flag_q unchanged, no X on any output.
REQ-038 SHALL cover: count=2, flag_q=1, drop rst_n between clock edges -> outputs clear immediately, and after release out_valid=0 until a new push.
